mux_nway_arb: RTL and testbench
===============================

# mux_nway_arb

Parametrised, registered N-way multiplexer with per-channel valid/ready handshakes, the next generation of the combinational 8-way 16-bit multiplexer. It selects one of CHANNELS input words, either by an explicit select (fixed mode) or by round-robin arbitration, and holds it in an output register under a valid/ready handshake. It sits between multiple producers (register-file read ports, I/O sources) and a single consumer such as the ALU operand bus.

## Interface
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 8, number of input channels (power of two, 2..32)
- SEL_W, log2(CHANNELS), select/grant width (derived, not overridden)

- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- RR_EN  input  1  1 = round-robin mode, 0 = fixed-select mode
- S  input  SEL_W  channel select, used only when RR_EN=0
- IN_DATA  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- IN_VALID  input  CHANNELS  per-channel data valid
- IN_READY  output  CHANNELS  per-channel accept, one-hot or zero
- Y  output  WIDTH  registered output word
- Y_VALID  output  1  Y holds an unconsumed word
- Y_READY  input  1  consumer accepts Y
- GRANT  output  SEL_W  channel index that produced the current Y

## Operation
- Output register "load" condition: LOAD = !Y_VALID || Y_READY.
- Candidate set: RR_EN=0 -> only channel S, if IN_VALID[S]; RR_EN=1 -> all i with IN_VALID[i].
- Winner (RR_EN=1): first valid channel scanning PTR, PTR+1, ..., wrapping mod CHANNELS.
- Transfer on input side: IN_READY[w] = LOAD && candidate w exists; all other IN_READY bits 0. IN_READY is combinational from IN_VALID, S, RR_EN, PTR, Y_VALID, Y_READY.
- On a clock edge with IN_READY[w]=1: Y <= word w, GRANT <= w, Y_VALID <= 1; if RR_EN=1, PTR <= (w+1) mod CHANNELS.
- On an edge with LOAD=1 and no candidate: Y_VALID <= 0; Y and GRANT hold last values.
- On an edge with LOAD=0 (Y_VALID=1, Y_READY=0): Y, GRANT, Y_VALID, PTR all hold; no IN_READY asserted.
- Fixed mode never modifies PTR; switching RR_EN takes effect on the next arbitration, PTR retained.
- S changes while Y_VALID && !Y_READY: no effect on held Y.
- Invalid channel (IN_VALID=0) never granted, in either mode.

## Timing
- Reset (RESET_N=0, asynchronous assert, released synchronously to CLK by the system): Y=0, Y_VALID=0, GRANT=0, PTR=0 (channel 0 highest priority). IN_READY is combinationally 1 on the winning channel during reset only if LOAD holds; the consumer must ignore inputs while in reset and no transfer is recorded.
- Reset mid-operation: pending Y discarded, Y_VALID drops immediately (no clock needed).
- Latency: input accepted at edge n -> Y/Y_VALID visible after edge n.
- Throughput: one word per cycle when Y_READY held 1 (simultaneous drain and load on the same edge).
- Fairness: with all CHANNELS valid continuously in RR mode, each channel granted exactly once per CHANNELS consecutive transfers.
- Backpressure: Y_READY=0 for k cycles stalls all inputs k cycles, no word lost or duplicated.

## Test plan
- Fixed mode sweep: CHANNELS=8, WIDTH=16, all valid, data ch0..7 = F000,0F00,00F0,000F,A000,0A00,00A0,000A, Y_READY=1, S=0..7 one per cycle -> Y follows one cycle late with same sequence, GRANT=S of previous cycle, IN_READY one-hot on S.
- Round-robin full load: same data, RR_EN=1, all valid, Y_READY=1 for 16 cycles -> GRANT 0,1,...,7,0,...,7; Y matches channel words in order.
- Sparse round-robin: only ch2 and ch6 valid, PTR=0 after reset -> GRANT 2,6,2,6; PTR wraps 7->0 correctly when ch7 then ch0 valid.
- Backpressure: Y_VALID=1 with Y=0F00, hold Y_READY=0 for 3 cycles while ch3 valid -> Y stays 0F00, IN_READY=0, then Y_READY=1 -> Y=000F next cycle, no drop.
- Empty/idle: all IN_VALID=0, Y_READY=1 -> Y_VALID falls to 0 after one edge, Y holds last value; fixed mode with IN_VALID[S]=0 and other channels valid -> nothing granted.
- Async reset: assert RESET_N=0 between edges while Y_VALID=1, Y=A000 -> Y=0, Y_VALID=0, GRANT=0 immediately; after release, RR starts from ch0.

Source files
------------

// File: rtl/mux_nway_arb_if.sv
`default_nettype none
// mux_nway_arb_if: producer-side channel bundle plus consumer-side output handshake.
// Revision 1.0
interface mux_nway_arb_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      rr_en;
  logic [SEL_W-1:0]          s;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;
  logic                      y_ready;
  logic [SEL_W-1:0]          grant;

  modport master (
    output rr_en, s, in_data, in_valid, y_ready,
    input  in_ready, y, y_valid, grant
  );

  modport slave (
    input  rr_en, s, in_data, in_valid, y_ready,
    output in_ready, y, y_valid, grant
  );
endinterface
`default_nettype wire

// File: rtl/mux_nway_arb.sv
`default_nettype none
// mux_nway_arb: registered N-way mux, fixed-select or round-robin, valid/ready on both sides.
// Revision 1.0
module mux_nway_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input logic          clk,
  input logic          rst_n,
  mux_nway_arb_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_win;
  logic [SEL_W-1:0] scan_idx;
  logic             rr_found;
  logic [SEL_W-1:0] win;
  logic             cand;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] win_word;

  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic [SEL_W-1:0] grant_q;

  assign load = !y_valid_q || bus.y_ready;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    scan_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      scan_idx = ptr + SEL_W'(k);
      if (bus.in_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx;
      end
    end
  end

  assign cand     = bus.rr_en ? rr_found : bus.in_valid[bus.s];
  assign win      = bus.rr_en ? rr_win : bus.s;
  assign take     = load && cand;
  assign win_word = bus.in_data[win*WIDTH +: WIDTH];

  assign bus.in_ready = take ? ({{(CHANNELS-1){1'b0}}, 1'b1} << win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      grant_q   <= '0;
      ptr       <= '0;
    end else if (load) begin
      y_valid_q <= cand;
      if (cand) begin
        y_q     <= win_word;
        grant_q <= win;
        if (bus.rr_en) begin
          ptr <= win + SEL_W'(1);
        end
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.grant   = grant_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_nway_arb.sv
`default_nettype none
`timescale 1ns/100ps
// tb_mux_nway_arb: queue scoreboard against a list-based reference of the arbitration rules.
// Revision 1.0
module tb_mux_nway_arb;
  localparam int W  = 16;
  localparam int CH = 8;
  localparam int SW = $clog2(CH);

  typedef struct {
    logic [W-1:0]  y;
    logic [SW-1:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   m_ptr = 0;
  int   m_valid = 0;
  logic [W-1:0] dir_data [CH] = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F,
                                  16'hA000, 16'h0A00, 16'h00A0, 16'h000A};

  mux_nway_arb_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  mux_nway_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [CH-1:0] v, input int p);
    for (int k = 0; k < CH; k++) begin
      if (v[(p + k) % CH]) return (p + k) % CH;
    end
    return -1;
  endfunction

  // Reference: decides the transfer for the coming rising edge.
  initial forever begin
    int w;
    bit ld;
    logic [CH-1:0] exp_rdy;
    @(negedge clk);
    #3;
    if (rst_n) begin
      ld = (m_valid == 0) || bus.y_ready;
      if (bus.rr_en) w = rr_pick(bus.in_valid, m_ptr);
      else           w = bus.in_valid[bus.s] ? int'(bus.s) : -1;
      exp_rdy = (ld && w >= 0) ? CH'(1 << w) : '0;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      if (ld) begin
        if (w >= 0) begin
          q.push_back('{y: bus.in_data[w*W +: W], g: SW'(w)});
          m_valid = 1;
          if (bus.rr_en) m_ptr = (w + 1) % CH;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Monitor: the held output must match the oldest unconsumed transfer.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("y_valid", 64'(bus.y_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("y", 64'(bus.y), 64'(q[0].y));
        chk("grant", 64'(bus.grant), 64'(q[0].g));
        if (bus.y_ready) void'(q.pop_front());
      end
    end
  end

  task automatic load_dir_data();
    for (int i = 0; i < CH; i++) bus.in_data[i*W +: W] = dir_data[i];
  endtask

  task automatic step(input logic rr, input int sel, input logic [CH-1:0] v, input logic yr);
    @(negedge clk);
    #1;
    bus.rr_en    = rr;
    bus.s        = SW'(sel);
    bus.in_valid = v;
    bus.y_ready  = yr;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_y"}, 64'(bus.y), 64'h0);
    chk({tag, "_y_valid"}, 64'(bus.y_valid), 64'h0);
    chk({tag, "_grant"}, 64'(bus.grant), 64'h0);
  endtask

  initial begin
    bus.rr_en    = 1'b0;
    bus.s        = '0;
    bus.in_valid = '0;
    bus.y_ready  = 1'b0;
    load_dir_data();
    #3;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < CH; i++) step(1'b0, i, '1, 1'b1);
    for (int i = 0; i < 2*CH; i++) step(1'b1, 0, '1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 8'b0100_0100, 1'b1);
    step(1'b1, 0, 8'b1000_0000, 1'b1);
    step(1'b1, 0, 8'b0000_0001, 1'b1);

    step(1'b0, 1, '1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 3, 8'b0000_1000, 1'b0);
    step(1'b0, 3, 8'b0000_1000, 1'b1);
    step(1'b0, 3, 8'b0000_0000, 1'b1);
    step(1'b0, 3, 8'b0000_0000, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 5, 8'b1101_1111, 1'b1);

    step(1'b0, 4, '1, 1'b1);
    step(1'b0, 2, '1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    m_ptr = 0;
    m_valid = 0;
    #0.5;
    check_reset_state("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 0, '1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < CH; i++) bus.in_data[i*W +: W] = W'($urandom);
      bus.rr_en    = 1'($urandom_range(0, 1));
      bus.s        = SW'($urandom_range(0, CH - 1));
      bus.in_valid = CH'($urandom);
      if ($urandom_range(0, 3) == 0) bus.in_valid = '1;
      bus.y_ready  = ($urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 3; i++) step(1'b1, 0, '0, 1'b1);
    @(negedge clk);
    #4;
    chk("drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
